// File: rtl/fnd_pkg.sv
// Shared display codes, controller states and range helpers for the FND scan controller.
package fnd_pkg;

  localparam logic [3:0] CODE_MINUS = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } fnd_state_e;

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  function automatic longint unsigned pos_max(input int n_digits);
    return pow10(n_digits) - 64'd1;
  endfunction

  // One digit is reserved for the sign, so the negative limit loses a decade.
  function automatic longint neg_min(input int n_digits);
    return -longint'(pow10(n_digits - 1) - 64'd1);
  endfunction

endpackage

// File: rtl/fnd_bin2bcd.sv
// Iterative double-dabble: one add-3/shift step per clock, VAL_W steps after start_i.
module fnd_bin2bcd #(
  parameter int VAL_W    = 14,
  parameter int N_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [VAL_W-1:0]      bin_i,
  output logic                  done_o,
  output logic [4*N_DIGITS-1:0] bcd_o
);
  localparam int CW = $clog2(VAL_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(VAL_W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [VAL_W-1:0]      shreg_q, shreg_d;
  logic [4*N_DIGITS-1:0] acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  active_q, active_d;

  function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
    if (nib >= 4'd5) return nib + 4'd3;
    else             return nib;
  endfunction

  assign done_o = active_q && (cnt_q == CNT_LAST);
  assign bcd_o  = acc_q;

  // Next-state for the shifter; the accumulator only needs N_DIGITS nibbles
  // since out-of-range values never display their digits.
  always_comb begin
    logic [3:0] nib;
    logic       cin;
    shreg_d  = shreg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    nib      = 4'd0;
    cin      = 1'b0;
    if (start_i) begin
      shreg_d  = bin_i;
      acc_d    = '0;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      cin = shreg_q[VAL_W-1];
      for (int i = 0; i < N_DIGITS; i++) begin
        nib = dabble_adj(acc_q[4*i +: 4]);
        acc_d[4*i +: 4] = {nib[2:0], cin};
        cin = nib[3];
      end
      shreg_d = {shreg_q[VAL_W-2:0], 1'b0};
      cnt_d   = cnt_q + CNT_ONE;
      if (cnt_q == CNT_LAST) active_d = 1'b0;
      else                   active_d = 1'b1;
    end else begin
      active_d = 1'b0;
    end
  end

  // Shifter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// N-digit 7-segment scan controller: signed load, BCD conversion, digit multiplexing.
// Build option FND_LZB_EN: leading-zero blanking with the minus sign next to the top digit.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int VAL_W    = 14,
  parameter int CLK_DIV  = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_valid,
  input  logic [VAL_W-1:0]    load_value,
  output logic                load_ready,
  output logic                busy,
  output logic                ovf,
  output logic [3:0]          digit_code,
  output logic [N_DIGITS-1:0] an_n
);
  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [PW-1:0]       PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0]       PRESC_ONE  = PW'(1);
  localparam logic [IW-1:0]       IDX_LAST   = IW'(N_DIGITS - 1);
  localparam logic [IW-1:0]       IDX_ONE    = IW'(1);
  localparam logic [N_DIGITS-1:0] AN_ONE     = N_DIGITS'(1);
  localparam logic [VAL_W-1:0]    VAL_ONE    = VAL_W'(1);
  localparam logic [63:0]         POS_LIM    = pos_max(N_DIGITS);
  localparam longint              NEG_MIN_L  = neg_min(N_DIGITS);
  localparam logic [63:0]         NEG_LIM    = 64'(-NEG_MIN_L);

  fnd_state_e               state_q, state_d;
  logic                     neg_q, neg_d, inrange_q, inrange_d, ovf_q, ovf_d;
  logic                     ready_q, busy_q;
  logic [N_DIGITS-1:0][3:0] disp_q, disp_d;
  logic [PW-1:0]            presc_q, presc_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [N_DIGITS-1:0]      an_q, an_d;
  logic [3:0]               code_q, code_d;
  logic                     xfer_s, conv_done_s, val_neg_s, val_inrange_s;
  logic [VAL_W-1:0]         mag_s;
  logic [63:0]              mag_wide_s;
  logic [4*N_DIGITS-1:0]    bcd_s;

  assign load_ready = ready_q;
  assign busy       = busy_q;
  assign ovf        = ovf_q;
  assign digit_code = code_q;
  assign an_n       = an_q;

  // Magnitude is taken as unsigned so the most negative input converts cleanly.
  always_comb begin
    xfer_s    = load_valid && (state_q == IDLE);
    val_neg_s = load_value[VAL_W-1];
    if (val_neg_s) mag_s = ~load_value + VAL_ONE;
    else           mag_s = load_value;
    mag_wide_s = 64'(mag_s);
    if (val_neg_s) val_inrange_s = (mag_wide_s <= NEG_LIM);
    else           val_inrange_s = (mag_wide_s <= POS_LIM);
  end

  fnd_bin2bcd #(
    .VAL_W    (VAL_W),
    .N_DIGITS (N_DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (xfer_s),
    .bin_i   (mag_s),
    .done_o  (conv_done_s),
    .bcd_o   (bcd_s)
  );

  // Control FSM next-state and load-time latches.
  always_comb begin
    state_d   = state_q;
    neg_d     = neg_q;
    inrange_d = inrange_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (xfer_s) begin
          state_d   = CONV;
          neg_d     = val_neg_s;
          inrange_d = val_inrange_s;
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        if (conv_done_s) state_d = COMMIT;
        else             state_d = CONV;
      end
      COMMIT: begin
        state_d = IDLE;
        ovf_d   = ~inrange_q;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FND_LZB_EN
  logic [3:0] msd_s;

  // Index of the most significant nonzero BCD digit (0 when the value is zero).
  always_comb begin
    msd_s = 4'd0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bcd_s[4*i +: 4] != 4'd0) msd_s = 4'(i);
      else                         msd_s = msd_s;
    end
  end
`endif

  // Display register is rebuilt only in COMMIT so the old value stays up during conversion.
  always_comb begin
    disp_d = disp_q;
    if (state_q == COMMIT) begin
      if (!inrange_q) begin
        for (int i = 0; i < N_DIGITS; i++) disp_d[i] = CODE_MINUS;
      end else begin
        for (int i = 0; i < N_DIGITS; i++) disp_d[i] = bcd_s[4*i +: 4];
`ifdef FND_LZB_EN
        for (int i = 1; i < N_DIGITS; i++) begin
          if (4'(i) > msd_s) disp_d[i] = CODE_BLANK;
          else               disp_d[i] = bcd_s[4*i +: 4];
          if (neg_q && (4'(i) == msd_s + 4'd1)) disp_d[i] = CODE_MINUS;
          else                                  disp_d[i] = disp_d[i];
        end
`else
        if (neg_q) disp_d[N_DIGITS-1] = CODE_MINUS;
        else       disp_d[N_DIGITS-1] = bcd_s[4*(N_DIGITS-1) +: 4];
`endif
      end
    end else begin
      disp_d = disp_q;
    end
  end

  // Prescaler and scan index; outputs are formed from the index being entered this edge.
  always_comb begin
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      if (idx_q == IDX_LAST) idx_d = '0;
      else                   idx_d = idx_q + IDX_ONE;
    end else begin
      presc_d = presc_q + PRESC_ONE;
      idx_d   = idx_q;
    end
    an_d   = ~(AN_ONE << idx_d);
    code_d = disp_q[idx_d];
  end

  // Control and display registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      neg_q     <= 1'b0;
      inrange_q <= 1'b0;
      ovf_q     <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      disp_q    <= {N_DIGITS{CODE_BLANK}};
    end else begin
      state_q   <= state_d;
      neg_q     <= neg_d;
      inrange_q <= inrange_d;
      ovf_q     <= ovf_d;
      ready_q   <= (state_d == IDLE);
      busy_q    <= (state_d != IDLE);
      disp_q    <= disp_d;
    end
  end

  // Scanner registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= ~AN_ONE;
      code_q  <= CODE_BLANK;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      code_q  <= code_d;
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Randomised self-checking bench for fnd_scan_ctrl against a decimal-arithmetic display model.
module tb_fnd_scan_ctrl;
  localparam int N  = 4;
  localparam int VW = 14;
  localparam int CD = 4;
  localparam int POS_MAX = 10**N - 1;
  localparam int NEG_LIM = 10**(N-1) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          load_valid = 1'b0;
  logic [VW-1:0] load_value = '0;
  logic          load_ready, busy, ovf;
  logic [3:0]    digit_code;
  logic [N-1:0]  an_n;

  int checks = 0;
  int errors = 0;

  fnd_scan_ctrl #(.N_DIGITS(N), .VAL_W(VW), .CLK_DIV(CD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_value (load_value),
    .load_ready (load_ready),
    .busy       (busy),
    .ovf        (ovf),
    .digit_code (digit_code),
    .an_n       (an_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic in_range(input int v);
    return (v <= POS_MAX) && (v >= -NEG_LIM);
  endfunction

  // Expected display contents for a value, digit i in bits [4i+3:4i].
  function automatic logic [4*N-1:0] render(input int v);
    logic [4*N-1:0] r;
    int mag, p, msd;
    if (!in_range(v)) return {N{4'd10}};
    mag = (v < 0) ? -v : v;
    p = 1;
    msd = 0;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'((mag / p) % 10);
      if ((mag / p) % 10 != 0) msd = i;
      p = p * 10;
    end
`ifdef FND_LZB_EN
    for (int i = msd + 1; i < N; i++) r[4*i +: 4] = 4'd11;
    if (v < 0) r[4*(msd+1) +: 4] = 4'd10;
`else
    if (v < 0) r[4*(N-1) +: 4] = 4'd10;
`endif
    return r;
  endfunction

  function automatic logic [N-1:0] an_of(input int idx);
    logic [N-1:0] a;
    a = '1;
    a[idx] = 1'b0;
    return a;
  endfunction

  function automatic int rand_val();
    int r;
    case ($urandom_range(0, 3))
      0:       r = int'($urandom_range(0, 99)) - 50;
      1:       r = int'($urandom_range(0, 10998)) - 999;
      2:       r = int'($urandom_range(0, 16383)) - 8192;
      default: r = int'($urandom_range(0, 2000)) - 1000;
    endcase
    return r;
  endfunction

  // Behavioural model: edges counted since reset, a countdown for the conversion latency.
  int             m_edges, m_busy, m_val, m_idx;
  logic [3:0]     m_code;
  logic           m_ovf;
  logic [4*N-1:0] m_disp;

  always @(posedge clk or negedge rst_n) begin : model
    int e;
    if (!rst_n) begin
      m_edges <= 0;
      m_busy  <= 0;
      m_val   <= 0;
      m_idx   <= 0;
      m_code  <= 4'd11;
      m_ovf   <= 1'b0;
      m_disp  <= {N{4'd11}};
    end else begin
      e = m_edges + 1;
      m_edges <= e;
      m_idx   <= (e / CD) % N;
      m_code  <= m_disp[4*((e / CD) % N) +: 4];
      if (m_busy == 0) begin
        if (load_valid) begin
          m_val  <= int'($signed(load_value));
          m_busy <= VW + 1;
        end
      end else begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_disp <= render(m_val);
          m_ovf  <= !in_range(m_val);
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("load_ready", load_ready, m_busy == 0);
    chk("busy", busy, m_busy != 0);
    chk("ovf", ovf, m_ovf);
    chk("an_n", an_n, an_of(m_idx));
    chk("digit_code", digit_code, m_code);
  end

  task automatic check_frame(input string nm, input logic [4*N-1:0] exp);
    int sel;
    for (int c = 0; c < N * CD; c++) begin
      @(negedge clk);
      sel = 0;
      for (int k = 0; k < N; k++) if (an_n[k] == 1'b0) sel = k;
      chk(nm, digit_code, exp[4*sel +: 4]);
    end
  endtask

  task automatic load(input int v);
    int n, len;
    n = 0;
    while (!load_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", n < 200, 1'b1);
    load_value = VW'(v);
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    len = 0;
    while (busy && len < 200) begin
      @(negedge clk);
      len++;
    end
    chk("busy_len", len, VW + 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int prev;
    #1 rst_n = 1'b0;

    chk("pin_1234", render(1234), 16'h1234);
    chk("pin_m1000", render(-1000), 16'hAAAA);
    chk("pin_m8192", render(-8192), 16'hAAAA);
    chk("pin_9999", render(9999), 16'h9999);
`ifdef FND_LZB_EN
    chk("pin_m42", render(-42), 16'hBA42);
    chk("pin_0", render(0), 16'hBBB0);
`else
    chk("pin_m42", render(-42), 16'hA042);
    chk("pin_0", render(0), 16'h0000);
`endif

    repeat (3) @(negedge clk);
    chk("rst_code", digit_code, 4'd11);
    chk("rst_an", an_n, 4'b1110);
    chk("rst_ready", load_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;

    check_frame("blank_frame", 16'hBBBB);
    check_frame("blank_frame", 16'hBBBB);

    load(1234);
    check_frame("frame_1234", 16'h1234);
    load(-42);
`ifdef FND_LZB_EN
    check_frame("frame_m42", 16'hBA42);
`else
    check_frame("frame_m42", 16'hA042);
`endif
    load(0);
`ifdef FND_LZB_EN
    check_frame("frame_0", 16'hBBB0);
`else
    check_frame("frame_0", 16'h0000);
`endif
    load(-1000);
    check_frame("frame_m1000", 16'hAAAA);
    chk("ovf_m1000", ovf, 1'b1);
    load(5);
    chk("ovf_clear", ovf, 1'b0);

    prev = -1;
    load_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      load_value = VW'($urandom_range(0, 16383));
      if (load_ready) begin
        if (prev >= 0) chk("xfer_gap", c - prev, VW + 2);
        prev = c;
      end
      @(negedge clk);
    end
    load_valid = 1'b0;
    repeat (VW + 4) @(negedge clk);

    load(-8192);
    check_frame("frame_m8192", 16'hAAAA);
    chk("ovf_m8192", ovf, 1'b1);

    for (int t = 0; t < 30; t++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      load(rand_val());
      repeat (N * CD) @(negedge clk);
    end

    load(77);
`ifdef FND_LZB_EN
    check_frame("frame_77", 16'hBB77);
`else
    check_frame("frame_77", 16'h0077);
`endif
    load_value = VW'(1234);
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_code", digit_code, 4'd11);
    chk("abort_an", an_n, 4'b1110);
    chk("abort_ready", load_ready, 1'b1);
    chk("abort_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    load(9);
`ifdef FND_LZB_EN
    check_frame("frame_9", 16'hBBB9);
`else
    check_frame("frame_9", 16'h0009);
`endif

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
